wb_commit: RTL and testbench
============================

# wb_commit

Writeback-stage commit unit of the five-stage MIPS pipeline. Captures the MEM/WB pipeline register each cycle and aligns and extends load data. Selects the writeback source and drives the single write port of the general register file, including the PC and instruction of the committing instruction. Also keeps a retired-instruction counter and flags misaligned halfword loads, which are squashed.

## Interface
Parameters:
- `CNT_W`, 32: width of the retired-instruction counter.

Ports:
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `flush`  in  1  turns the incoming slot into a bubble.
- `valid_M`  in  1  MEM stage holds a real instruction.
- `pcMEM`  in  32  PC of the MEM-stage instruction.
- `instrMEM`  in  32  instruction word from the MEM stage.
- `we_M`  in  1  instruction writes a GPR.
- `waddr_M`  in  5  destination register number.
- `wb_sel_M`  in  2  writeback source: 0 ALU, 1 memory, 2 PC+8, 3 HI/LO.
- `ld_type_M`  in  3  load type: 0 LW, 1 LB, 2 LBU, 3 LH, 4 LHU; 5–7 are treated as LW.
- `alu_M`  in  32  ALU result; for loads this is the effective address.
- `rdata_M`  in  32  raw word read from data memory.
- `hilo_M`  in  32  HI/LO value for mfhi/mflo.
- `RegWrite`  out  1  register-file write enable.
- `RegAddr`  out  5  register-file write address.
- `RegData`  out  32  register-file write data.
- `pcWB`  out  32  PC of the committing instruction.
- `instrWB`  out  32  instruction word of the committing instruction.
- `ld_misalign`  out  1  the committing LH/LHU had address bit 0 set.
- `retired`  out  CNT_W  count of committed valid instructions.

## Operation
- **Capture.** On each rising edge, the WB register loads every `*_M` input and sets `valid_W = valid_M & ~flush`. There is no stall: WB never holds an instruction for more than one cycle.
- **Load extraction** uses `off = alu_W[1:0]`:
  - LW: the full word.
  - LB/LBU: byte `rdata_W[8*off+7:8*off]`; LB sign-extends, LBU zero-extends.
  - LH/LHU: halfword `rdata_W[16*off[1]+15:16*off[1]]`; LH sign-extends, LHU zero-extends.
- **Source mux** for `RegData`:
  - `wb_sel_W` 0 → `alu_W`.
  - 1 → extended load data.
  - 2 → `pc_W + 8`, mod 2^32.
  - 3 → `hilo_W`.
- **Misalignment.** `ld_misalign = valid_W & (ld_type_W is 3 or 4) & alu_W[0]` and `wb_sel_W == 1`.
- **Write enable.** `RegWrite = valid_W & we_W & (waddr_W != 0) & ~ld_misalign`. Writes to $0 never assert `RegWrite`.
- **Outputs.** `RegAddr = waddr_W` and `pcWB = pc_W` are driven even when `RegWrite` is 0. `instrWB = valid_W ? instr_W : 0`.
- **Retire counter.** `retired` increments by 1 on each edge at which `valid_W` is 1 and `ld_misalign` is 0. It wraps from all-ones to 0. Non-writing instructions (stores, branches) also count.

## Timing
- **Latency.** Inputs presented before edge N appear on `RegWrite`/`RegAddr`/`RegData` during cycle N, combinationally from the WB register. The register file samples them at edge N+1.
- **Reset value.** `reset` low clears every WB register field and `retired` immediately, without waiting for a clock edge. While held low and after release: `RegWrite`=0, `RegAddr`=0, `RegData`=0, `pcWB`=0, `instrWB`=0, `ld_misalign`=0, `retired`=0.
  - Exception: with wb_sel 0 all fields zero, so `RegData`=0 holds. `pc_W+8` is never selected at reset.
- **Reset mid-operation.** The instruction in WB is discarded and not counted.
- **Flush with valid_M.** A `flush` coinciding with `valid_M`=1 produces a bubble: no write and no count. `pcWB` still takes `pcMEM`.
- **Back-to-back writes.** Consecutive writes to the same register commit in consecutive cycles, each exactly once.
- **PC wrap.** `pc_W = 32'hFFFF_FFFC` with wb_sel 2 gives `RegData = 32'h0000_0004`.

## Configuration
- **`WB_TRACE_EN` defined:** on each edge where `RegWrite` is 1, the block prints `"<time>@<pcWB hex>: $<RegAddr> <= <RegData hex>"` via `$display`.
  - On each edge where `ld_misalign` is 1, it prints `"<time>@<pcWB hex>: misaligned load"`.
- **`WB_TRACE_EN` undefined:** no simulation output; hardware behaviour is identical.

## Test plan
- **Reset.** Drive `valid_M`=1 and `we_M`=1, then pull `reset` low mid-cycle → all outputs go to 0 immediately, and `retired` stays 0 until after release.
- **Sign/zero extension.** LB with `alu_M=32'h1002`, `rdata_M=32'h12F45678`, waddr 8 → cycle after: `RegWrite`=1, `RegAddr`=8, `RegData=32'hFFFFFFF4`. The same case as LBU → `32'h000000F4`.
- **Misaligned halfword.** LH with `alu_M=32'h1001` → `ld_misalign`=1, `RegWrite`=0, `retired` unchanged. LHU at `32'h1002`, rdata `32'h8001_0000` → `RegData=32'h00008001`.
- **jal and $0.** jal (wb_sel 2, waddr 31) at `pcMEM=32'h3000` → `RegData=32'h3008`. An ALU op with waddr 0 → `RegWrite`=0, `retired`+1.
- **Flush.** Flush on 3 of 10 consecutive valid instructions → exactly 7 writes, `retired`=7.
- **Counter wrap.** With `CNT_W`=4, 17 valid commits → `retired`=1.

Source files
------------

// File: rtl/wb_commit.sv
// Writeback commit stage: MEM/WB register, load align/extend, GPR write port, retire counter.
// Optional `WB_TRACE_EN` prints a commit trace in simulation.
module wb_commit #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             valid_M,
    input  logic [31:0]      pcMEM,
    input  logic [31:0]      instrMEM,
    input  logic             we_M,
    input  logic [4:0]       waddr_M,
    input  logic [1:0]       wb_sel_M,
    input  logic [2:0]       ld_type_M,
    input  logic [31:0]      alu_M,
    input  logic [31:0]      rdata_M,
    input  logic [31:0]      hilo_M,
    output logic             RegWrite,
    output logic [4:0]       RegAddr,
    output logic [31:0]      RegData,
    output logic [31:0]      pcWB,
    output logic [31:0]      instrWB,
    output logic             ld_misalign,
    output logic [CNT_W-1:0] retired
);

    typedef enum logic [2:0] {
        LdW   = 3'd0,
        LdB   = 3'd1,
        LdBu  = 3'd2,
        LdH   = 3'd3,
        LdHu  = 3'd4
    } ld_type_e;

    logic        valid_W;
    logic [31:0] pc_W;
    logic [31:0] instr_W;
    logic        we_W;
    logic [4:0]  waddr_W;
    logic [1:0]  wb_sel_W;
    logic [2:0]  ld_type_W;
    logic [31:0] alu_W;
    logic [31:0] rdata_W;
    logic [31:0] hilo_W;

    logic [31:0] loadData;
    logic [7:0]  byteVal;
    logic [15:0] halfVal;
    logic        isHalf;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_W   <= 1'b0;
            pc_W      <= '0;
            instr_W   <= '0;
            we_W      <= 1'b0;
            waddr_W   <= '0;
            wb_sel_W  <= '0;
            ld_type_W <= '0;
            alu_W     <= '0;
            rdata_W   <= '0;
            hilo_W    <= '0;
        end else begin
            valid_W   <= valid_M & ~flush;
            pc_W      <= pcMEM;
            instr_W   <= instrMEM;
            we_W      <= we_M;
            waddr_W   <= waddr_M;
            wb_sel_W  <= wb_sel_M;
            ld_type_W <= ld_type_M;
            alu_W     <= alu_M;
            rdata_W   <= rdata_M;
            hilo_W    <= hilo_M;
        end
    end

    always_comb begin
        byteVal  = rdata_W[8*alu_W[1:0] +: 8];
        halfVal  = alu_W[1] ? rdata_W[31:16] : rdata_W[15:0];
        loadData = rdata_W;
        case (ld_type_W)
            LdB:     loadData = {{24{byteVal[7]}}, byteVal};
            LdBu:    loadData = {24'h0, byteVal};
            LdH:     loadData = {{16{halfVal[15]}}, halfVal};
            LdHu:    loadData = {16'h0, halfVal};
            default: loadData = rdata_W;
        endcase
    end

    always_comb begin
        RegData = alu_W;
        case (wb_sel_W)
            2'd0: RegData = alu_W;
            2'd1: RegData = loadData;
            2'd2: RegData = pc_W + 32'd8;
            2'd3: RegData = hilo_W;
            default: RegData = alu_W;
        endcase
    end

    assign isHalf      = (ld_type_W == LdH) || (ld_type_W == LdHu);
    assign ld_misalign = valid_W & isHalf & alu_W[0] & (wb_sel_W == 2'd1);
    assign RegWrite    = valid_W & we_W & (waddr_W != 5'd0) & ~ld_misalign;
    assign RegAddr     = waddr_W;
    assign pcWB        = pc_W;
    assign instrWB     = valid_W ? instr_W : 32'h0;

    // Squashed misaligned loads do not retire; bubbles never do.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            retired <= '0;
        end else if (valid_W && !ld_misalign) begin
            retired <= retired + CNT_W'(1);
        end
    end

`ifdef WB_TRACE_EN
    always @(posedge clk) begin
        if (RegWrite) begin
            $display("%0t@%h: $%0d <= %h", $time, pcWB, RegAddr, RegData);
        end
        if (ld_misalign) begin
            $display("%0t@%h: misaligned load", $time, pcWB);
        end
    end
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: directed vector table, corner sequences, random vs model.
module tb_wb_commit;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        valid_M;
    logic [31:0] pcMEM;
    logic [31:0] instrMEM;
    logic        we_M;
    logic [4:0]  waddr_M;
    logic [1:0]  wb_sel_M;
    logic [2:0]  ld_type_M;
    logic [31:0] alu_M;
    logic [31:0] rdata_M;
    logic [31:0] hilo_M;

    logic        RegWrite, RegWrite4;
    logic [4:0]  RegAddr, RegAddr4;
    logic [31:0] RegData, RegData4;
    logic [31:0] pcWB, pcWB4;
    logic [31:0] instrWB, instrWB4;
    logic        ld_misalign, ld_misalign4;
    logic [31:0] retired;
    logic [3:0]  retired4;

    int checks = 0;
    int errors = 0;
    int cnt = 0;
    int writes = 0;

    always #5 clk = ~clk;

    wb_commit #(.CNT_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush), .valid_M(valid_M), .pcMEM(pcMEM),
        .instrMEM(instrMEM), .we_M(we_M), .waddr_M(waddr_M), .wb_sel_M(wb_sel_M),
        .ld_type_M(ld_type_M), .alu_M(alu_M), .rdata_M(rdata_M), .hilo_M(hilo_M),
        .RegWrite(RegWrite), .RegAddr(RegAddr), .RegData(RegData), .pcWB(pcWB),
        .instrWB(instrWB), .ld_misalign(ld_misalign), .retired(retired)
    );

    wb_commit #(.CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .flush(flush), .valid_M(valid_M), .pcMEM(pcMEM),
        .instrMEM(instrMEM), .we_M(we_M), .waddr_M(waddr_M), .wb_sel_M(wb_sel_M),
        .ld_type_M(ld_type_M), .alu_M(alu_M), .rdata_M(rdata_M), .hilo_M(hilo_M),
        .RegWrite(RegWrite4), .RegAddr(RegAddr4), .RegData(RegData4), .pcWB(pcWB4),
        .instrWB(instrWB4), .ld_misalign(ld_misalign4), .retired(retired4)
    );

    typedef struct {
        string       name;
        logic        v, f, we;
        logic [4:0]  wa;
        logic [1:0]  ws;
        logic [2:0]  lt;
        logic [31:0] alu, rd, hl, pc;
        logic        expRw;
        logic [31:0] expData;
        logic        expMis;
    } vec_t;

    vec_t tv[15];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: result of one instruction, straight from the ISA load/writeback rules.
    function automatic logic [31:0] modelData(input logic [1:0] ws, input logic [2:0] lt,
                                              input logic [31:0] alu, input logic [31:0] rd,
                                              input logic [31:0] hl, input logic [31:0] pc);
        logic [31:0] sh;
        int off;
        off = int'(alu & 32'd3);
        case (ws)
            2'd0: return alu;
            2'd2: return pc + 32'd8;
            2'd3: return hl;
            default: begin
                if (lt == 3'd1 || lt == 3'd2) begin
                    sh = rd >> (8 * off);
                    if (lt == 3'd1) return {{24{sh[7]}}, sh[7:0]};
                    return {24'h0, sh[7:0]};
                end
                if (lt == 3'd3 || lt == 3'd4) begin
                    sh = rd >> (16 * (off / 2));
                    if (lt == 3'd3) return {{16{sh[15]}}, sh[15:0]};
                    return {16'h0, sh[15:0]};
                end
                return rd;
            end
        endcase
    endfunction

    task automatic applyIn(input logic v, input logic f, input logic we, input logic [4:0] wa,
                           input logic [1:0] ws, input logic [2:0] lt, input logic [31:0] alu,
                           input logic [31:0] rd, input logic [31:0] hl, input logic [31:0] pc);
        valid_M = v; flush = f; we_M = we; waddr_M = wa; wb_sel_M = ws; ld_type_M = lt;
        alu_M = alu; rdata_M = rd; hilo_M = hl; pcMEM = pc; instrMEM = pc ^ 32'hA5A5_0000;
    endtask

    // Clock the applied inputs into WB and compare every output with the model.
    task automatic stepChk(input string nm);
        logic live, mis, rw;
        live = valid_M & ~flush;
        mis = live && (ld_type_M == 3'd3 || ld_type_M == 3'd4) && alu_M[0] && wb_sel_M == 2'd1;
        rw = live && we_M && waddr_M != 5'd0 && !mis;
        @(posedge clk);
        #1;
        check({nm, ".RegWrite"}, 32'(RegWrite), 32'(rw));
        check({nm, ".RegAddr"}, 32'(RegAddr), 32'(waddr_M));
        check({nm, ".RegData"}, RegData,
              modelData(wb_sel_M, ld_type_M, alu_M, rdata_M, hilo_M, pcMEM));
        check({nm, ".pcWB"}, pcWB, pcMEM);
        check({nm, ".instrWB"}, instrWB, live ? instrMEM : 32'h0);
        check({nm, ".ld_misalign"}, 32'(ld_misalign), 32'(mis));
        check({nm, ".retired"}, retired, cnt);
        check({nm, ".retired4"}, 32'(retired4), 32'(cnt & 15));
        if (RegWrite) writes++;
        if (live && !mis) cnt++;
    endtask

    task automatic pulseReset();
        reset = 1'b0;
        #1;
        cnt = 0;
        reset = 1'b1;
    endtask

    initial begin
        tv[0]  = '{"lb",        1,0,1, 8,1,1,32'h1002,32'h12F45678,0,32'h1000, 1,32'hFFFFFFF4,0};
        tv[1]  = '{"lbu",       1,0,1, 8,1,2,32'h1002,32'h12F45678,0,32'h1000, 1,32'h000000F4,0};
        tv[2]  = '{"lh_mis",    1,0,1, 9,1,3,32'h1001,32'h12F45678,0,32'h1004, 0,32'h00005678,1};
        tv[3]  = '{"lhu",       1,0,1, 9,1,4,32'h1002,32'h80010000,0,32'h1008, 1,32'h00008001,0};
        tv[4]  = '{"lh_hi",     1,0,1, 9,1,3,32'h1002,32'h80010000,0,32'h100C, 1,32'hFFFF8001,0};
        tv[5]  = '{"jal",       1,0,1,31,2,0,32'h0,   32'h0,       0,32'h3000, 1,32'h00003008,0};
        tv[6]  = '{"alu_r0",    1,0,1, 0,0,0,32'h1234,32'h0,       0,32'h3004, 0,32'h00001234,0};
        tv[7]  = '{"pc_wrap",   1,0,1, 4,2,0,32'h0,   32'h0,       0,32'hFFFFFFFC,1,32'h4,     0};
        tv[8]  = '{"hilo",      1,0,1, 3,3,0,32'h0,   32'h0,32'hDEADBEEF,32'h10, 1,32'hDEADBEEF,0};
        tv[9]  = '{"lw",        1,0,1, 6,1,0,32'h1003,32'hCAFEBABE,0,32'h14,   1,32'hCAFEBABE,0};
        tv[10] = '{"lt7_as_lw", 1,0,1, 6,1,7,32'h1001,32'hCAFEBABE,0,32'h18,   1,32'hCAFEBABE,0};
        tv[11] = '{"lb_off3",   1,0,1, 7,1,1,32'h1003,32'h80123456,0,32'h1C,   1,32'hFFFFFF80,0};
        tv[12] = '{"flush",     1,1,1, 7,0,0,32'h55,  32'h0,       0,32'h20,   0,32'h00000055,0};
        tv[13] = '{"lhu_mis",   1,0,1, 7,1,4,32'h1003,32'h12345678,0,32'h24,   0,32'h00001234,1};
        tv[14] = '{"lh_alu",    1,0,1, 7,0,3,32'h1001,32'h0,       0,32'h28,   1,32'h00001001,0};

        // Reset state while held low.
        reset = 1'b0;
        applyIn(1, 0, 1, 5'd5, 2'd2, 3'd0, 32'h77, 32'h0, 32'h0, 32'h4000);
        #1;
        check("rst.RegWrite", 32'(RegWrite), 0);
        check("rst.RegData", RegData, 0);
        check("rst.pcWB", pcWB, 0);
        check("rst.retired", retired, 0);
        @(posedge clk);
        #1;
        check("rst_held.RegAddr", 32'(RegAddr), 0);
        check("rst_held.instrWB", instrWB, 0);
        check("rst_held.ld_misalign", 32'(ld_misalign), 0);
        reset = 1'b1;

        for (int i = 0; i < 15; i++) begin
            applyIn(tv[i].v, tv[i].f, tv[i].we, tv[i].wa, tv[i].ws, tv[i].lt, tv[i].alu,
                    tv[i].rd, tv[i].hl, tv[i].pc);
            stepChk(tv[i].name);
            check({tv[i].name, ".vecRw"}, 32'(RegWrite), 32'(tv[i].expRw));
            check({tv[i].name, ".vecData"}, RegData, tv[i].expData);
            check({tv[i].name, ".vecMis"}, 32'(ld_misalign), 32'(tv[i].expMis));
        end

        // Reset mid-cycle with a writing instruction in WB.
        applyIn(1, 0, 1, 5'd12, 2'd0, 3'd0, 32'h99, 32'h0, 32'h0, 32'h5000);
        stepChk("pre_rst");
        #3;
        reset = 1'b0;
        #1;
        cnt = 0;
        check("midrst.RegWrite", 32'(RegWrite), 0);
        check("midrst.RegAddr", 32'(RegAddr), 0);
        check("midrst.RegData", RegData, 0);
        check("midrst.pcWB", pcWB, 0);
        check("midrst.instrWB", instrWB, 0);
        check("midrst.retired", retired, 0);
        @(posedge clk);
        #1;
        check("midrst_held.retired", retired, 0);
        reset = 1'b1;
        applyIn(0, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        stepChk("post_rst");
        check("post_rst.retired0", retired, 0);

        // Ten back-to-back writes to one register, three flushed.
        pulseReset();
        writes = 0;
        for (int i = 0; i < 10; i++) begin
            applyIn(1, (i == 2 || i == 5 || i == 8), 1, 5'd5, 2'd0, 3'd0, 32'(i), 32'h0,
                    32'h0, 32'h6000 + 32'(4 * i));
            stepChk("b2b");
        end
        applyIn(0, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        stepChk("b2b_drain");
        check("flush.writes", 32'(writes), 7);
        check("flush.retired", retired, 7);

        // Counter wrap on the narrow instance.
        pulseReset();
        for (int i = 0; i < 17; i++) begin
            applyIn(1, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h7000);
            stepChk("wrap");
        end
        applyIn(0, 0, 0, 5'd0, 2'd0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0);
        stepChk("wrap_drain");
        check("wrap.retired4", 32'(retired4), 1);
        check("wrap.retired32", retired, 17);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            applyIn(($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), 1'($urandom),
                    5'($urandom), 2'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
                    $urandom);
            stepChk("rand");
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
